// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a START/DATA/PARITY/STOP serialiser with a runtime baud divisor.
// Latency: a word pushed into an empty FIFO with an idle line starts its start bit one clk later.
// Backpressure: in_ready drops only when the FIFO is full; frames chain back-to-back while words remain.

// Small generic FIFO: first-word-fall-through head, registered pointers and occupancy count.
module uart_tx_fifo_buf #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_vld_i,
  input  logic [W-1:0]  push_dat_i,
  output logic          push_rdy_o,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // The count never exceeds DEPTH, so its top bit alone marks "full".
  assign push_rdy_o = ~count_q[AW];
  assign do_push    = push_vld_i & push_rdy_o;
  assign do_pop     = pop_i & (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Next pointers and occupancy; simultaneous push and pop leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     fifo_count
);

  // Reject unsupported frame formats when the design is built.
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY == 1);
  localparam logic       PAR_EN    = (PARITY != 0);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   pop;
  logic                   load;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   head_dat;
  logic [FIFO_AW:0]       count;

  uart_tx_fifo_buf #(
    .W  (DATA_BITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_vld_i (in_valid),
    .push_dat_i (in_data),
    .push_rdy_o (in_ready),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign bit_end    = (cnt_q == '0);
  assign tx_out     = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign fifo_count = count;

  // Frame sequencing: every bit lasts div_q+1 cycles; tx_d carries the level of the bit being entered.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count != '0) load = 1'b1;
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[1];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = div_q;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when a word is waiting.
            if (count != '0) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            cnt_d = div_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: take the FIFO head and freeze the divisor for the whole frame.
    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      div_d   = baud_div;
      cnt_d   = baud_div;
      bit_d   = '0;
      shift_d = head_dat;
      par_d   = (^head_dat) ^ PAR_ODD;
      tx_d    = 1'b0;
    end
  end

  // Serialiser state; reset abandons any frame in flight and returns the line to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule
